// File: rtl/lfsr_t4b_chk.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : lfsr_t4b_chk                                                  |
// | Function : Pattern checker for a type-4 (internal-XOR) 8-bit LFSR        |
// |            stream. Seeds on the first received word, tracks the stream,  |
// |            flags mismatching words and drops lock after LOSS_THRESH      |
// |            consecutive misses. Keeps saturating word/error counters.     |
// | Options  : define LFSR_T4B_CHK_HD_EN to accumulate the Hamming distance  |
// |            between consecutive accepted words on hd_sum (else tied 0).   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module lfsr_t4b_chk #(
  parameter int LOSS_THRESH = 3,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [6:0]       cfg_tap,
  input  logic             in_valid,
  input  logic [0:7]       in_data,
  input  logic             clr_stats,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] word_cnt,
  output logic [11:0]      hd_sum
);

  localparam logic [3:0] c_loss_thresh = 4'(LOSS_THRESH);

  typedef enum logic [1:0] {
    ST_UNCFG  = 2'd0,
    ST_SEEK   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t           r_state;
  logic [6:0]       r_tap;
  logic [0:7]       r_exp;
  logic [3:0]       r_miss;
  logic             r_locked;
  logic             r_err;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_word_cnt;

  state_t           w_state_nxt;
  logic [6:0]       w_tap_nxt;
  logic [0:7]       w_exp_nxt;
  logic [3:0]       w_miss_nxt;
  logic [3:0]       w_miss_inc;
  logic             w_err_nxt;
  logic [CNT_W-1:0] w_err_cnt_nxt;
  logic [CNT_W-1:0] w_word_cnt_nxt;
  logic             w_accept;
  logic             w_mismatch;

  // One generator step: bit 7 wraps to bit 0 and is XORed into every tapped
  // position on its way down; tap[6] lands on bit 1, tap[0] on bit 7.
  function automatic logic [0:7] f_next(input logic [0:7] x, input logic [6:0] t);
    f_next = {x[7], x[0:6] ^ (t & {7{x[7]}})};
  endfunction

  // Next-state, prediction, miss counter and statistics for this cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_tap_nxt      = r_tap;
    w_exp_nxt      = r_exp;
    w_miss_nxt     = r_miss;
    w_miss_inc     = r_miss + 4'd1;
    w_err_nxt      = 1'b0;
    w_err_cnt_nxt  = r_err_cnt;
    w_word_cnt_nxt = r_word_cnt;
    w_accept       = 1'b0;
    w_mismatch     = 1'b0;

    if (cfg_valid) begin
      // Reconfiguration overrides any word presented in the same cycle.
      w_tap_nxt   = cfg_tap;
      w_miss_nxt  = 4'd0;
      w_state_nxt = ST_SEEK;
    end else if (in_valid) begin
      case (r_state)
        ST_SEEK: begin
          w_accept    = 1'b1;
          w_exp_nxt   = f_next(in_data, r_tap);
          w_state_nxt = ST_LOCKED;
        end
        ST_LOCKED: begin
          w_accept = 1'b1;
          if (in_data == r_exp) begin
            w_exp_nxt  = f_next(in_data, r_tap);
            w_miss_nxt = 4'd0;
          end else begin
            // Flywheel: keep predicting from our own sequence, not the bad word.
            w_mismatch = 1'b1;
            w_err_nxt  = 1'b1;
            w_exp_nxt  = f_next(r_exp, r_tap);
            if (w_miss_inc == c_loss_thresh) begin
              w_state_nxt = ST_SEEK;
              w_miss_nxt  = 4'd0;
            end else begin
              w_miss_nxt = w_miss_inc;
            end
          end
        end
        default: ;
      endcase
    end

    if (w_accept && (r_word_cnt != '1)) w_word_cnt_nxt = r_word_cnt + 1'b1;
    if (w_mismatch && (r_err_cnt != '1)) w_err_cnt_nxt = r_err_cnt + 1'b1;

    // Clearing wins over any increment made by this cycle's word.
    if (clr_stats) begin
      w_err_cnt_nxt  = '0;
      w_word_cnt_nxt = '0;
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_UNCFG;
      r_tap      <= 7'd0;
      r_exp      <= 8'd0;
      r_miss     <= 4'd0;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
      r_err_cnt  <= '0;
      r_word_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tap      <= w_tap_nxt;
      r_exp      <= w_exp_nxt;
      r_miss     <= w_miss_nxt;
      r_locked   <= (w_state_nxt == ST_LOCKED);
      r_err      <= w_err_nxt;
      r_err_cnt  <= w_err_cnt_nxt;
      r_word_cnt <= w_word_cnt_nxt;
    end
  end

  assign locked   = r_locked;
  assign err      = r_err;
  assign err_cnt  = r_err_cnt;
  assign word_cnt = r_word_cnt;

`ifdef LFSR_T4B_CHK_HD_EN
  logic [0:7]  r_hist;
  logic        r_hist_vld;
  logic [11:0] r_hd_sum;
  logic [0:7]  w_hist_nxt;
  logic        w_hist_vld_nxt;
  logic [11:0] w_hd_sum_nxt;
  logic [3:0]  w_hd_add;
  logic [12:0] w_hd_acc;

  // Hamming distance of each accepted word against the previous accepted one.
  always_comb begin
    w_hist_nxt     = r_hist;
    w_hist_vld_nxt = r_hist_vld;
    w_hd_add       = 4'd0;
    w_hd_sum_nxt   = r_hd_sum;

    if (cfg_valid) begin
      w_hist_vld_nxt = 1'b0;
    end else if (w_accept) begin
      if (r_hist_vld) w_hd_add = 4'($countones(in_data ^ r_hist));
      w_hist_nxt     = in_data;
      w_hist_vld_nxt = 1'b1;
    end

    w_hd_acc = {1'b0, r_hd_sum} + {9'd0, w_hd_add};
    if (clr_stats)        w_hd_sum_nxt = 12'd0;
    else if (w_hd_acc[12]) w_hd_sum_nxt = 12'hFFF;
    else                   w_hd_sum_nxt = w_hd_acc[11:0];
  end

  // History and distance accumulator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist     <= 8'd0;
      r_hist_vld <= 1'b0;
      r_hd_sum   <= 12'd0;
    end else begin
      r_hist     <= w_hist_nxt;
      r_hist_vld <= w_hist_vld_nxt;
      r_hd_sum   <= w_hd_sum_nxt;
    end
  end

  assign hd_sum = r_hd_sum;
`else
  assign hd_sum = 12'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lfsr_t4b_chk.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_lfsr_t4b_chk                                               |
// | Function : Self-checking bench for lfsr_t4b_chk: directed scenarios plus |
// |            randomized traffic against a behavioural stream model.        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_lfsr_t4b_chk;

  localparam int LOSS  = 3;
  localparam int CW    = 8;
  localparam int CMAX  = 255;
  localparam int HDMAX = 4095;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          cfg_valid = 1'b0;
  logic [6:0]    cfg_tap   = 7'd0;
  logic          in_valid  = 1'b0;
  logic [0:7]    in_data   = 8'd0;
  logic          clr_stats = 1'b0;
  logic          locked;
  logic          err;
  logic [CW-1:0] err_cnt;
  logic [CW-1:0] word_cnt;
  logic [11:0]   hd_sum;

  lfsr_t4b_chk #(.LOSS_THRESH(LOSS), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_tap   (cfg_tap),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clr_stats (clr_stats),
    .locked    (locked),
    .err       (err),
    .err_cnt   (err_cnt),
    .word_cnt  (word_cnt),
    .hd_sum    (hd_sum)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Behavioural model: mode 0 = unconfigured, 1 = seeking, 2 = tracking.
  int       m_mode;
  bit [6:0] m_tap;
  bit [0:7] m_exp;
  int       m_miss;
  bit [0:7] m_prev;
  bit       m_have_prev;
  int       m_err;
  int       m_errc;
  int       m_wc;
  int       m_hd;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [0:7] m_next(input bit [0:7] x, input bit [6:0] t);
    bit [0:7] n;
    n[0] = x[7];
    for (int i = 1; i < 8; i++) n[3'(i)] = x[3'(i - 1)] ^ (t[3'(7 - i)] & x[7]);
    return n;
  endfunction

  function automatic int popcnt(input bit [0:7] v);
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(v[3'(i)]);
    return c;
  endfunction

  function automatic int exp_hd();
`ifdef LFSR_T4B_CHK_HD_EN
    return m_hd;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_mode = 0; m_tap = '0; m_exp = '0; m_miss = 0;
    m_prev = '0; m_have_prev = 1'b0;
    m_err = 0; m_errc = 0; m_wc = 0; m_hd = 0;
  endtask

  task automatic model_step(input bit cv, input bit [6:0] ct, input bit iv,
                            input bit [0:7] d, input bit clr);
    bit acc = 1'b0;
    bit mis = 1'b0;
    int add = 0;
    m_err = 0;
    if (cv) begin
      m_tap = ct; m_miss = 0; m_have_prev = 1'b0; m_mode = 1;
    end else if (iv && m_mode != 0) begin
      acc = 1'b1;
      if (m_mode == 1) begin
        m_exp = m_next(d, m_tap); m_mode = 2;
      end else if (d == m_exp) begin
        m_exp = m_next(d, m_tap); m_miss = 0;
      end else begin
        mis = 1'b1; m_err = 1;
        m_exp = m_next(m_exp, m_tap);
        m_miss++;
        if (m_miss == LOSS) begin m_mode = 1; m_miss = 0; end
      end
      if (m_have_prev) add = popcnt(d ^ m_prev);
      m_prev = d; m_have_prev = 1'b1;
    end
    if (clr) begin
      m_errc = 0; m_wc = 0; m_hd = 0;
    end else begin
      if (acc) m_wc = (m_wc + 1 > CMAX) ? CMAX : m_wc + 1;
      if (mis) m_errc = (m_errc + 1 > CMAX) ? CMAX : m_errc + 1;
      m_hd = (m_hd + add > HDMAX) ? HDMAX : m_hd + add;
    end
  endtask

  // Drive one clock cycle of inputs; called from the low clock phase.
  task automatic cycle(input bit cv, input bit [6:0] ct, input bit iv,
                       input bit [0:7] d, input bit clr);
    cfg_valid = cv; cfg_tap = ct; in_valid = iv; in_data = d; clr_stats = clr;
    @(posedge clk);
    model_step(cv, ct, iv, d, clr);
    @(negedge clk);
    cfg_valid = 1'b0; in_valid = 1'b0; clr_stats = 1'b0;
  endtask

  task automatic word(input bit [0:7] d);
    cycle(1'b0, 7'd0, 1'b1, d, 1'b0);
  endtask

  // Asynchronous reset pulse placed away from both clock edges.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1 model_reset();
    chk("rst_locked", int'(locked), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_word_cnt", int'(word_cnt), 0);
    chk("rst_hd_sum", int'(hd_sum), 0);
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  // Every cycle the model is active, all outputs must equal the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("locked", int'(locked), (m_mode == 2) ? 1 : 0);
      chk("err", int'(err), m_err);
      chk("err_cnt", int'(err_cnt), m_errc);
      chk("word_cnt", int'(word_cnt), m_wc);
      chk("hd_sum", int'(hd_sum), exp_hd());
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit [6:0] tap;
    bit [0:7] w;
    model_reset();
    chk_en = 1'b1;
    #12 rst = 1'b0;
    @(negedge clk);

    // Pin the model's generator step against a hand-derived value.
    tap = 7'b0100101;
    chk("model_next", int'(m_next(8'b00001111, tap)), int'(8'b10100010));

    // Seed and lock on a known stream.
    do_reset();
    cycle(1'b1, tap, 1'b0, 8'd0, 1'b0);
    word(8'b00001111);
    chk("seed_locked", int'(locked), 1);
    word(8'b10100010);
    chk("stream_word_cnt", int'(word_cnt), 2);
    chk("stream_err", int'(err), 0);
`ifdef LFSR_T4B_CHK_HD_EN
    chk("stream_hd_sum", int'(hd_sum), 5);
`endif

    // Single corrupted word with bit 0 flipped; flywheel keeps lock.
    w = m_next(8'b10100010, tap);
    word(w ^ 8'b10000000);
    chk("corrupt_err", int'(err), 1);
    chk("corrupt_err_cnt", int'(err_cnt), 1);
    chk("corrupt_locked", int'(locked), 1);
    w = m_next(w, tap);
    word(w);
    chk("recover_err", int'(err), 0);
    w = m_next(w, tap);
    word(w);
    chk("recover_err_cnt", int'(err_cnt), 1);
    chk("recover_locked", int'(locked), 1);

    // Three consecutive misses drop lock on the third.
    for (int k = 0; k < 3; k++) begin
      word(~m_exp);
      chk("loss_err", int'(err), 1);
      chk("loss_locked", int'(locked), (k < 2) ? 1 : 0);
    end
    chk("loss_err_cnt", int'(err_cnt), 4);
    word(8'h5A);
    chk("relock_locked", int'(locked), 1);
    chk("relock_err", int'(err), 0);
    chk("relock_word_cnt", int'(word_cnt), 9);

    // Configuration in the same cycle as a word: the word is ignored.
    cycle(1'b1, tap, 1'b1, 8'h33, 1'b0);
    chk("cfgword_word_cnt", int'(word_cnt), 9);
    chk("cfgword_locked", int'(locked), 0);
    word(8'h33);
    chk("cfgword_relock", int'(locked), 1);

    // Clear coinciding with a mismatching word.
    cycle(1'b0, 7'd0, 1'b1, ~m_exp, 1'b1);
    chk("clr_err", int'(err), 1);
    chk("clr_err_cnt", int'(err_cnt), 0);
    chk("clr_word_cnt", int'(word_cnt), 0);
    chk("clr_hd_sum", int'(hd_sum), 0);

    // 300 mismatches while holding lock: counters saturate.
    for (int k = 0; k < 150; k++) begin
      word(m_exp);
      word(~m_exp);
      word(~m_exp);
    end
    chk("sat_err_cnt", int'(err_cnt), 255);
    chk("sat_word_cnt", int'(word_cnt), 255);

    // Large distances between words saturate the distance accumulator.
    cycle(1'b1, 7'b1011000, 1'b0, 8'd0, 1'b0);
    for (int k = 0; k < 520; k++) word((k % 2 == 0) ? 8'h00 : 8'hFF);
`ifdef LFSR_T4B_CHK_HD_EN
    chk("sat_hd_sum", int'(hd_sum), 4095);
`endif

    // Reset mid-stream: words are ignored until reconfigured.
    do_reset();
    word(8'h81);
    word(8'h42);
    chk("post_rst_word_cnt", int'(word_cnt), 0);
    chk("post_rst_locked", int'(locked), 0);

    // Randomized traffic with occasional reconfig, clears and resets.
    for (int k = 0; k < 3000; k++) begin
      bit       cv;
      bit       iv;
      bit       clr;
      bit [6:0] ct;
      bit [0:7] d;
      if ($urandom_range(0, 599) == 0) do_reset();
      cv  = ($urandom_range(0, 39) == 0);
      ct  = 7'($urandom);
      iv  = ($urandom_range(0, 3) != 0);
      d   = ($urandom_range(0, 9) < 7) ? m_exp : 8'($urandom);
      clr = ($urandom_range(0, 49) == 0);
      cycle(cv, ct, iv, d, clr);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lfsr_t4b_chk.md
LFSR_T4B_CHK -- requirements
Module: lfsr_t4b_chk

Interface
REQ-001 Parameter: LOSS_THRESH, 3, consecutive mismatches that drop lock (legal 1..15).
REQ-002 Parameter: CNT_W, 8, width of err_cnt and word_cnt.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port: rst  input  1  reset; asynchronous, active-high.
REQ-005 Port: cfg_valid  input  1  load cfg_tap this cycle.
REQ-006 Port: cfg_tap  input  7  tap vector, same encoding as the type-4 generator (tap[6] feeds bit 1 ... tap[0] feeds bit 7).
REQ-007 Port: in_valid  input  1  in_data holds one received pattern word.
REQ-008 Port: in_data  input  [0:7]  received pattern, bit 0 = MSB position of generator register P.
REQ-009 Port: clr_stats  input  1  synchronous clear of err_cnt, word_cnt, hd_sum.
REQ-010 Port: locked  output  1  checker is tracking the stream.
REQ-011 Port: err  output  1  one-cycle pulse: previous accepted word mismatched prediction.
REQ-012 Port: err_cnt  output  CNT_W  saturating mismatch count.
REQ-013 Port: word_cnt  output  CNT_W  saturating count of accepted words.
REQ-014 Port: hd_sum  output  12  accumulated Hamming distance between consecutive accepted words.

Function
REQ-015 next(X,t): n[0]=X[7]; n[i]=X[i-1]^(t[7-i]&X[7]) for i=1..7; t=0 gives pure rotation.
REQ-016 States UNCFG, SEEK, LOCKED; locked=1 only in LOCKED; all outputs registered.
REQ-017 cfg_valid in any state: tap<=cfg_tap, miss<=0, hd history cleared, state->SEEK; a same-cycle in_valid word is ignored; stats unchanged.
REQ-018 UNCFG: in_valid ignored, no counter changes.
REQ-019 SEEK, in_valid: exp<=next(in_data,tap), state->LOCKED, word_cnt+1, no err.
REQ-020 LOCKED, in_valid, in_data==exp: exp<=next(in_data,tap), miss<=0, word_cnt+1.
REQ-021 LOCKED, in_valid, in_data!=exp: err=1 next cycle, err_cnt+1, word_cnt+1, miss+1, exp<=next(exp,tap) (flywheel).
REQ-022 Mismatch making miss==LOSS_THRESH: state->SEEK, locked=0 same edge as err, miss<=0.
REQ-023 err, locked, counters update on the edge after the in_valid cycle (latency 1); back-to-back in_valid every cycle supported.
REQ-024 err_cnt, word_cnt, hd_sum saturate at all-ones; never wrap.
REQ-025 clr_stats wins over same-cycle increments; that word's contributions are discarded; state/exp still update.
REQ-026 in_valid low: no state, exp, or counter change; err=0.

Reset
REQ-027 rst asserted: state=UNCFG, tap=0, exp=0, miss=0, history cleared; locked=0, err=0, err_cnt=0, word_cnt=0, hd_sum=0, immediately and independent of clk.
REQ-028 rst mid-stream discards lock; a new cfg_valid is required before words are accepted.

Configuration
REQ-029 Macro LFSR_T4B_CHK_HD_EN defined: each accepted word after the first since reset/cfg adds popcount(in_data ^ previous accepted word) to hd_sum.
REQ-030 LFSR_T4B_CHK_HD_EN undefined: no HD logic; hd_sum tied to 0; all other behaviour identical.

Verification
REQ-031 rst; cfg_tap=0100101; words 00001111, 10100010 -> locked=1 after word 1, err=0, word_cnt=2, hd_sum=5 (HD_EN).
REQ-032 Locked on above stream; corrupt one word (bit 0 flipped), next words correct -> single err pulse, err_cnt=1, locked stays 1.
REQ-033 LOSS_THRESH=3; three consecutive wrong words -> err pulses x3, locked=0 on third; next word reseeds and relocks.
REQ-034 cfg_valid and in_valid same cycle -> word ignored, word_cnt unchanged, state SEEK.
REQ-035 clr_stats with a mismatching word -> err_cnt=0, word_cnt=0, hd_sum=0; err pulse still asserted.
REQ-036 Force err_cnt path 300 mismatches with CNT_W=8 -> err_cnt holds 255; rst mid-stream -> all outputs 0 asynchronously.
